// File: rtl/sr_dbg_pkg.sv
// sr_dbg_pkg: shared FSM state type, line terminator characters and hex-to-ASCII helper.
package sr_dbg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETADDR, S_LOAD, S_SEND, S_NEXT, S_FIN} state_t;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/sr_reg_dump_uart_if.sv
// sr_reg_dump_uart_if: CPU debug register port, address out from the dumper, data back combinationally.
interface sr_reg_dump_uart_if;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  modport master (output regAddr, input regData);
  modport slave  (input regAddr, output regData);
endinterface

// File: rtl/sr_uart_tx.sv
// sr_uart_tx: 8N1 UART transmitter with valid/ready byte input, ready only while idle.
module sr_uart_tx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  if (DIV < 2) begin : g_div_chk
    $error("sr_uart_tx: CLK_HZ/BAUD must be at least 2");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    frame_q, frame_d;
  logic          act_q, act_d, tx_q, tx_d;
  logic          bit_end;
  assign bit_end = cnt_q == CW'(DIV - 1);
  assign ready   = !act_q;
  assign tx      = tx_q;
  // The frame is latched whole at accept and only indexed afterwards, so it never shifts mid-frame.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    act_d   = act_q;
    tx_d    = tx_q;
    if (!act_q) begin
      if (valid) begin
        frame_d = {1'b1, data, 1'b0};
        act_d   = 1'b1;
        cnt_d   = '0;
        bit_d   = 4'd0;
        tx_d    = 1'b0;
      end
    end else if (bit_end) begin
      cnt_d = '0;
      if (bit_q == 4'd9) begin
        act_d = 1'b0;
        tx_d  = 1'b1;
      end else begin
        bit_d = bit_q + 4'd1;
        tx_d  = frame_q[bit_q + 4'd1];
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      frame_q <= '1;
      act_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      act_q   <= act_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// File: rtl/sr_reg_dump_uart.sv
// sr_reg_dump_uart: walks debug registers FIRST_REG..LAST_REG and prints each as 8 hex digits + CR LF over UART.
module sr_reg_dump_uart
  import sr_dbg_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  sr_reg_dump_uart_if.master   dbg,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  if (FIRST_REG < 0 || LAST_REG > 31 || LAST_REG < FIRST_REG) begin : g_range_chk
    $error("sr_reg_dump_uart: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end
  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);
  state_t      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  idx_q, idx_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        tx_valid, tx_ready;
  logic [3:0]  nib;
  logic [7:0]  tx_char;
  assign dbg.regAddr = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign nib      = 4'(word_q >> (5'd28 - {idx_q[2:0], 2'b00}));
  assign tx_char  = idx_q == 4'd8 ? CHAR_CR : idx_q == 4'd9 ? CHAR_LF : hex2ascii(nib);
  assign tx_valid = state_q == S_SEND && idx_q < 4'd10;
  // idx reaches 10 once the LF is accepted; ready returning then means its stop bit has ended.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        addr_d  = FIRST;
        busy_d  = 1'b1;
        state_d = S_SETADDR;
      end
      S_SETADDR: state_d = S_LOAD;
      S_LOAD: begin
        word_d  = dbg.regData;
        idx_d   = 4'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_valid && tx_ready) idx_d = idx_q + 4'd1;
        else if (idx_q == 4'd10 && tx_ready) state_d = S_NEXT;
      end
      S_NEXT: if (addr_q == LAST) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_FIN;
      end else begin
        addr_d  = addr_q + 5'd1;
        state_d = S_SETADDR;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 5'd0;
      word_q  <= 32'd0;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  sr_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (tx_char),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (tx)
  );
endmodule
